// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: BCD digit type,
// controller state encoding and the BCD digit clamp helper.
package score_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ADD     = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam bcd_t BCD_NINE = 4'd9;

  // Point digits above 9 are not valid BCD; treat them as 9.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Point-request bus between game sources and the score keeper.
//
// Handshake: source i raises req[i] and holds points[i*8+:8] stable while
// req[i] is high. gnt[i] is a one-cycle, one-hot pulse; the points are
// captured on the clock edge that ends the gnt cycle, so the source keeps
// req[i] high through that edge and may drop it afterwards. Dropping req
// before gnt withdraws the request.
interface score_keeper_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] points;
  logic [NREQ-1:0]   gnt;

  modport master (output req, output points, input gnt);
  modport slave  (input req, input points, output gnt);
endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: {cout, sum} = a + b + cin with decimal correction.
// One instance is time-shared across all score digits.
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t sum,
  output logic cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  // Binary add, then wrap by ten when the digit overflows.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj  = raw - 5'd10;
    cout = 1'b0;
    sum  = raw[3:0];
    if (raw > 5'd9) begin
      cout = 1'b1;
      sum  = adj[3:0];
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Player score keeper: round-robin arbitration of point requests, digit-serial
// BCD addition, bonus-life pulses, saturation at all nines and a display copy
// that only moves on frame_start.
// Optional feature macro HISCORE_EN adds hi_digits / new_hiscore outputs.
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int NREQ        = 4,
  parameter int BONUS_DIGIT = 3
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                clear,
  input  logic                frame_start,
  score_keeper_if.slave       req_if,
  output logic [DIGITS*4-1:0] disp_digits,
  output logic                busy,
  output logic                bonus_life,
  output logic                saturated,
`ifdef HISCORE_EN
  output logic [DIGITS*4-1:0] hi_digits,
  output logic                new_hiscore,
`endif
  output state_t              state_dbg
);

  localparam int W     = DIGITS * 4;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [W-1:0]     ALL_NINES   = {DIGITS{BCD_NINE}};
  localparam logic [CNT_W-1:0] LAST_DIGIT  = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BONUS_SRC   = CNT_W'(BONUS_DIGIT - 1);
  localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(NREQ - 1);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic             pick_valid;
  logic             any_req;
  int               arb_off;
  int               arb_best;

  logic [7:0]       operand;
  logic [W-1:0]     work;
  logic [W-1:0]     score;
  logic [W-1:0]     disp;
  logic [W-1:0]     commit_val;
  logic [CNT_W-1:0] dig_cnt;
  logic             carry;
  logic             bonus_hit;
  logic             sat_q;

  bcd_t             add_a;
  bcd_t             add_b;
  bcd_t             add_sum;
  logic             add_cout;

  assign any_req     = |req_if.req;
  assign busy        = (state != IDLE);
  assign disp_digits = disp;
  assign saturated   = sat_q;
  assign state_dbg   = state;

  // Round-robin pick: the requester closest at or after ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    arb_best   = NREQ;
    arb_off    = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_off = (i - int'(ptr) + NREQ) % NREQ;
      if (req_if.req[i] && (arb_off < arb_best)) begin
        arb_best   = arb_off;
        pick_idx   = PTR_W'(i);
        pick_valid = 1'b1;
      end
    end
  end

  assign ptr_nxt = (pick_idx == LAST_REQ) ? '0 : (pick_idx + PTR_W'(1));

  // Grant only in CAPTURE and never while a clear is in progress.
  always_comb begin
    req_if.gnt = '0;
    if ((state == CAPTURE) && pick_valid && !clear) begin
      req_if.gnt[pick_idx] = 1'b1;
    end
  end

  // Select the work digit and operand digit for the current add cycle.
  always_comb begin
    add_a = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_cnt == CNT_W'(i)) begin
        add_a = work[i*4 +: 4];
      end
    end
    if (dig_cnt == '0) begin
      add_b = bcd_clamp(operand[3:0]);
    end else if (dig_cnt == CNT_W'(1)) begin
      add_b = bcd_clamp(operand[7:4]);
    end else begin
      add_b = '0;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Final value written in COMMIT: overflow or an earlier clamp pins all nines.
  assign commit_val = (carry || sat_q) ? ALL_NINES : work;

  // A threshold crossing only counts when the add did not end in saturation.
  assign bonus_life = (state == COMMIT) && !clear && bonus_hit && !carry && !sat_q;

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; COMMIT goes straight to CAPTURE when work is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CAPTURE;
      CAPTURE: state_nxt = pick_valid ? ADD : IDLE;
      ADD:     if (dig_cnt == LAST_DIGIT) state_nxt = COMMIT;
      COMMIT:  state_nxt = any_req ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  // Datapath: operand capture, digit-serial add, commit and display copy.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ptr       <= '0;
      operand   <= '0;
      work      <= '0;
      score     <= '0;
      disp      <= '0;
      dig_cnt   <= '0;
      carry     <= 1'b0;
      bonus_hit <= 1'b0;
      sat_q     <= 1'b0;
    end else if (clear) begin
      work      <= '0;
      score     <= '0;
      disp      <= '0;
      dig_cnt   <= '0;
      carry     <= 1'b0;
      bonus_hit <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      // score only moves in COMMIT, so this always copies a committed value
      if (frame_start) begin
        disp <= score;
      end
      case (state)
        CAPTURE: begin
          if (pick_valid) begin
            for (int i = 0; i < NREQ; i++) begin
              if (pick_idx == PTR_W'(i)) begin
                operand <= req_if.points[i*8 +: 8];
              end
            end
            ptr       <= ptr_nxt;
            work      <= score;
            dig_cnt   <= '0;
            carry     <= 1'b0;
            bonus_hit <= 1'b0;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (dig_cnt == CNT_W'(i)) begin
              work[i*4 +: 4] <= add_sum;
            end
          end
          carry <= add_cout;
          if (add_cout && (dig_cnt == BONUS_SRC)) begin
            bonus_hit <= 1'b1;
          end
          dig_cnt <= dig_cnt + CNT_W'(1);
        end
        COMMIT: begin
          work  <= commit_val;
          score <= commit_val;
          if (carry) begin
            sat_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HISCORE_EN
  // High score tracks the best committed score; survives clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hi_digits   <= '0;
      new_hiscore <= 1'b0;
    end else if (clear) begin
      new_hiscore <= 1'b0;
    end else if ((state == COMMIT) && (commit_val > hi_digits)) begin
      hi_digits   <= commit_val;
      new_hiscore <= 1'b1;
    end
  end
`endif

endmodule
